// File: rtl/stepper_drive_output.sv
// Stepper driver output stage: a step/dir pulse generator with microstep
// position tracking and microstep-mode sequencing, plus a serial DAC writer
// that pushes the peak-current code to the driver's reference DAC.
module stepper_drive_output #(
  parameter int unsigned STEP_HIGH = 4,
  parameter int unsigned SCLK_DIV  = 4,
  parameter logic [3:0]  DAC_CMD   = 4'b0011
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dir_in,
  input  logic [15:0] step_period,
  input  logic [1:0]  usteps,
  input  logic [7:0]  peak_current,
  output logic        step,
  output logic        dir,
  output logic [1:0]  ms,
  output logic [2:0]  ustep_idx,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_sdi,
  output logic        dac_busy
);

  // The period is never allowed below twice the pulse width so every pulse
  // has at least as much low time as high time.
  localparam logic [15:0] MIN_PERIOD = 16'(2 * STEP_HIGH);
  localparam logic [15:0] HIGH_LAST  = 16'(STEP_HIGH - 1);
  localparam logic [15:0] HALF_LAST  = 16'(SCLK_DIV - 1);
  localparam logic [15:0] GAP_LAST   = 16'(2 * SCLK_DIV - 1);
  localparam logic [4:0]  LAST_HALF  = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } dac_state_e;

  // Step generator state
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_q, period_d;
  logic [15:0] high_cnt_q, high_cnt_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic [1:0]  ms_q, ms_d;
  logic [2:0]  ustep_idx_q, ustep_idx_d;

  // DAC writer state
  dac_state_e  state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  last_code_q, last_code_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        sdi_q, sdi_d;

  logic        running;
  logic [15:0] live_period;
  logic [15:0] cur_period;
  logic        terminal;
  logic [2:0]  ustep_delta;

  // A new period is only picked up at the start of an interval (count 0),
  // so an interval in flight always runs to its latched length.
  assign running     = enable && (step_period != 16'd0);
  assign live_period = (step_period < MIN_PERIOD) ? MIN_PERIOD : step_period;
  assign cur_period  = (cnt_q == 16'd0) ? live_period : period_q;
  assign terminal    = running && (cnt_q == (cur_period - 16'd1));

  // Position increment per step for the active microstep mode (full step = 8/8 = 0 mod 8).
  always_comb begin
    ustep_delta = 3'd0;
    case (ms_q)
      2'b11:   ustep_delta = 3'd1;
      2'b10:   ustep_delta = 3'd2;
      2'b01:   ustep_delta = 3'd4;
      default: ustep_delta = 3'd0;
    endcase
  end

  // Step counter, pulse shaper, position tracking and dir/ms sequencing.
  always_comb begin
    cnt_d       = cnt_q;
    period_d    = period_q;
    high_cnt_d  = high_cnt_q;
    step_d      = step_q;
    dir_d       = dir_q;
    ms_d        = ms_q;
    ustep_idx_d = ustep_idx_q;

    if (!running) begin
      cnt_d = 16'd0;
    end else if (terminal) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (running) begin
      period_d = cur_period;
    end

    if (terminal) begin
      step_d      = 1'b1;
      high_cnt_d  = HIGH_LAST;
      ustep_idx_d = dir_q ? (ustep_idx_q + ustep_delta) : (ustep_idx_q - ustep_delta);
    end else if (step_q) begin
      if (high_cnt_q == 16'd0) begin
        step_d = 1'b0;
      end else begin
        high_cnt_d = high_cnt_q - 16'd1;
      end
    end

    if (!step_q && !terminal) begin
      dir_d = dir_in;
    end

    if (!step_q && (ustep_idx_q == 3'd0)) begin
      ms_d = usteps;
    end
  end

  // Step generator registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 16'd0;
      period_q    <= MIN_PERIOD;
      high_cnt_q  <= 16'd0;
      step_q      <= 1'b0;
      dir_q       <= 1'b0;
      ms_q        <= 2'b11;
      ustep_idx_q <= 3'd0;
    end else begin
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      high_cnt_q  <= high_cnt_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      ms_q        <= ms_d;
      ustep_idx_q <= ustep_idx_d;
    end
  end

  // DAC writer next state: a frame is 32 SCLK half-periods, data changes on falling edges.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    last_code_d = last_code_q;
    shreg_d     = shreg_q;
    div_d       = div_q;
    half_d      = half_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    sdi_d       = sdi_q;

    case (state_q)
      IDLE: begin
        if (peak_current != last_code_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        code_d  = peak_current;
        shreg_d = {DAC_CMD, peak_current, 4'b0000};
        sdi_d   = DAC_CMD[3];
        cs_n_d  = 1'b0;
        sclk_d  = 1'b0;
        div_d   = 16'd0;
        half_d  = 5'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (div_q == HALF_LAST) begin
          div_d  = 16'd0;
          half_d = half_q + 5'd1;
          if (!half_q[0]) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (half_q == LAST_HALF) begin
              cs_n_d      = 1'b1;
              sdi_d       = 1'b0;
              last_code_d = code_q;
              state_d     = GAP;
            end else begin
              sdi_d   = shreg_q[14];
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = 16'd0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // DAC writer registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      code_q      <= 8'h00;
      last_code_q <= 8'h00;
      shreg_q     <= 16'h0000;
      div_q       <= 16'd0;
      half_q      <= 5'd0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      last_code_q <= last_code_d;
      shreg_q     <= shreg_d;
      div_q       <= div_d;
      half_q      <= half_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      sdi_q       <= sdi_d;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign ms        = ms_q;
  assign ustep_idx = ustep_idx_q;
  assign dac_cs_n  = cs_n_q;
  assign dac_sclk  = sclk_q;
  assign dac_sdi   = sdi_q;
  assign dac_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_stepper_drive_output.sv
// Directed testbench for stepper_drive_output: step timing, microstep
// sequencing, serial DAC frames and reset abort behaviour.
module tb_stepper_drive_output;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        dir_in;
  logic [15:0] step_period;
  logic [1:0]  usteps;
  logic [7:0]  peak_current;
  logic        step;
  logic        dir;
  logic [1:0]  ms;
  logic [2:0]  ustep_idx;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_sdi;
  logic        dac_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          frameCount = 0;
  logic [15:0] monShift = 16'h0;
  logic [15:0] lastFrame = 16'h0;
  int          monBits = 0;
  int          lastBits = 0;
  int          monLow = 0;
  int          lastLow = 0;
  int          riseCyc = 0;
  int          sdiViol = 0;
  logic        prevCs = 1'b1;
  logic        prevSclk = 1'b0;
  logic        prevSdi = 1'b0;

  int expIdx;
  logic [1:0] expMs;
  logic expDir;

  stepper_drive_output #(
    .STEP_HIGH(4),
    .SCLK_DIV(4),
    .DAC_CMD(4'b0011)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .dir_in(dir_in),
    .step_period(step_period),
    .usteps(usteps),
    .peak_current(peak_current),
    .step(step),
    .dir(dir),
    .ms(ms),
    .ustep_idx(ustep_idx),
    .dac_cs_n(dac_cs_n),
    .dac_sclk(dac_sclk),
    .dac_sdi(dac_sdi),
    .dac_busy(dac_busy)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Free-running count of active clock edges, used to time pulses and frames
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // DAC bus monitor: rebuilds each frame from SDI sampled at SCLK rising edges
  initial forever begin
    @(negedge clk);
    if (dac_cs_n === 1'b0 && prevCs === 1'b1) begin
      monBits = 0;
      monShift = 16'h0;
      monLow = 0;
    end
    if (dac_cs_n === 1'b0) begin
      monLow++;
      if (dac_sclk === 1'b1 && prevSclk === 1'b0) begin
        monShift = {monShift[14:0], dac_sdi};
        monBits++;
      end
      if (prevCs === 1'b0 && dac_sdi !== prevSdi && !(prevSclk === 1'b1 && dac_sclk === 1'b0))
        sdiViol++;
    end
    if (dac_cs_n === 1'b1 && prevCs === 1'b0) begin
      lastFrame = monShift;
      lastBits = monBits;
      lastLow = monLow;
      riseCyc = cyc;
      frameCount++;
    end
    prevCs = dac_cs_n;
    prevSclk = dac_sclk;
    prevSdi = dac_sdi;
  end

  // Counts one comparison and reports it when the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives all functional inputs on the inactive clock edge
  task automatic applyStimulus(input logic en, input logic d, input logic [15:0] per,
                               input logic [1:0] us, input logic [7:0] pk);
    @(negedge clk);
    enable = en;
    dir_in = d;
    step_period = per;
    usteps = us;
    peak_current = pk;
  endtask

  function automatic int deltaFor(input logic [1:0] m);
    case (m)
      2'b11: return 1;
      2'b10: return 2;
      2'b01: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic advanceModel();
    if (expDir) expIdx = (expIdx + deltaFor(expMs)) % 8;
    else        expIdx = (expIdx + 8 - deltaFor(expMs)) % 8;
  endtask

  task automatic waitStepRise(output int rc);
    int n = 0;
    while (step === 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (step !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checkOutput("step_rise_seen", step, 1);
    rc = cyc;
  endtask

  task automatic measureHigh(output int w);
    w = 0;
    while (step === 1'b1 && w < 100) begin w++; @(negedge clk); end
  endtask

  task automatic waitFrames(input int target);
    int n = 0;
    while (frameCount < target && n < 3000) begin @(negedge clk); n++; end
    checkOutput("frame_seen", frameCount >= target, 1);
  endtask

  task automatic waitBusyLow();
    int n = 0;
    while (dac_busy !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    checkOutput("busy_drop_seen", dac_busy, 0);
  endtask

  task automatic waitBitsInFrame(input int nbits);
    int n = 0;
    while (dac_cs_n !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    while (monBits < nbits && n < 1000) begin @(negedge clk); n++; end
    checkOutput("frame_bits_reached", (monBits >= nbits) && (dac_cs_n === 1'b0), 1);
  endtask

  initial begin
    int c0, rc, prevRise, w, n, rises, n0, n1, n2, gap;
    reset = 1'b1;
    enable = 1'b0;
    dir_in = 1'b0;
    step_period = 16'd0;
    usteps = 2'b11;
    peak_current = 8'h00;
    repeat (3) @(negedge clk);

    checkOutput("rst_step", step, 0);
    checkOutput("rst_dir", dir, 0);
    checkOutput("rst_ms", ms, 2'b11);
    checkOutput("rst_idx", ustep_idx, 0);
    checkOutput("rst_cs_n", dac_cs_n, 1);
    checkOutput("rst_sclk", dac_sclk, 0);
    checkOutput("rst_sdi", dac_sdi, 0);
    checkOutput("rst_busy", dac_busy, 0);
    reset = 1'b0;

    // 1/8 stepping at 100-cycle period, forward
    expIdx = 0;
    expMs = 2'b11;
    expDir = 1'b1;
    prevRise = 0;
    applyStimulus(1'b1, 1'b1, 16'd100, 2'b11, 8'h00);
    c0 = cyc;
    for (int k = 1; k <= 8; k++) begin
      waitStepRise(rc);
      if (k == 1) checkOutput("first_rise_delay", rc - c0, 100);
      else        checkOutput("period_100", rc - prevRise, 100);
      advanceModel();
      checkOutput("idx_fwd", ustep_idx, expIdx);
      measureHigh(w);
      checkOutput("width_100", w, 4);
      prevRise = rc;
    end
    checkOutput("idx_wrapped", ustep_idx, 0);

    // Period 3 clamps to 8; the running 100-cycle interval is not cut short
    applyStimulus(1'b1, 1'b1, 16'd3, 2'b11, 8'h00);
    for (int k = 1; k <= 3; k++) begin
      waitStepRise(rc);
      checkOutput(k == 1 ? "period_untruncated" : "period_clamped", rc - prevRise, k == 1 ? 100 : 8);
      advanceModel();
      checkOutput("idx_clamped", ustep_idx, expIdx);
      measureHigh(w);
      checkOutput("width_clamped", w, 4);
      prevRise = rc;
    end

    // Full-step request at idx 3 waits for the position to wrap to 0
    applyStimulus(1'b1, 1'b1, 16'd3, 2'b00, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      waitStepRise(rc);
      advanceModel();
      checkOutput("idx_pending_ms", ustep_idx, expIdx);
      checkOutput("ms_held", ms, 2'b11);
      measureHigh(w);
    end
    @(negedge clk);
    checkOutput("ms_full_applied", ms, 2'b00);
    expMs = 2'b00;
    for (int k = 1; k <= 2; k++) begin
      waitStepRise(rc);
      advanceModel();
      checkOutput("idx_full_step", ustep_idx, expIdx);
      measureHigh(w);
    end

    // Quarter stepping in reverse
    applyStimulus(1'b1, 1'b0, 16'd3, 2'b10, 8'h00);
    expMs = 2'b10;
    expDir = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      waitStepRise(rc);
      advanceModel();
      checkOutput("idx_reverse", ustep_idx, expIdx);
      checkOutput("ms_quarter", ms, 2'b10);
      checkOutput("dir_reverse", dir, 0);
      measureHigh(w);
    end

    // Disable mid-pulse: the pulse keeps its full width and nothing follows
    waitStepRise(rc);
    advanceModel();
    checkOutput("idx_before_stop", ustep_idx, expIdx);
    applyStimulus(1'b0, 1'b0, 16'd3, 2'b10, 8'h00);
    n = 0;
    while (step === 1'b1 && n < 50) begin @(negedge clk); n++; end
    checkOutput("stop_pulse_width", cyc - rc, 4);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (step === 1'b1) rises++;
    end
    checkOutput("stopped_no_pulse", rises, 0);
    checkOutput("stopped_idx_hold", ustep_idx, expIdx);

    // One DAC frame for code 0x5A
    n0 = frameCount;
    applyStimulus(1'b0, 1'b0, 16'd3, 2'b10, 8'h5A);
    waitFrames(n0 + 1);
    checkOutput("frame_5a", lastFrame, 16'h35A0);
    checkOutput("frame_5a_bits", lastBits, 16);
    checkOutput("frame_5a_cs_low", lastLow, 128);
    checkOutput("busy_in_gap", dac_busy, 1);
    waitBusyLow();
    checkOutput("gap_length", cyc - riseCyc, 8);
    repeat (50) @(negedge clk);
    checkOutput("no_repeat_frame", frameCount, n0 + 1);

    // Reset in the middle of a frame and of a step pulse
    applyStimulus(1'b1, 1'b1, 16'd8, 2'b11, 8'h5A);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n1 = frameCount;
    waitBitsInFrame(8);
    n = 0;
    while (step !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checkOutput("step_high_at_reset", step, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_cs_n", dac_cs_n, 1);
    checkOutput("abort_step", step, 0);
    checkOutput("abort_busy", dac_busy, 0);
    checkOutput("abort_sclk", dac_sclk, 0);
    checkOutput("abort_idx", ustep_idx, 0);
    checkOutput("abort_ms", ms, 2'b11);
    @(negedge clk);
    checkOutput("abort_recorded", frameCount, n1 + 1);
    checkOutput("abort_partial", lastBits < 16, 1);
    enable = 1'b0;
    reset = 1'b0;
    n2 = frameCount;

    // Resent 0x5A frame; code changes to 0x80 around bit 5
    waitBitsInFrame(5);
    peak_current = 8'h80;
    waitFrames(n2 + 1);
    checkOutput("resent_frame", lastFrame, 16'h35A0);
    checkOutput("resent_bits", lastBits, 16);
    n = 0;
    while (dac_cs_n !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    gap = cyc - riseCyc;
    checkOutput("gap_before_next", (gap >= 8) && (gap <= 12), 1);
    waitFrames(n2 + 2);
    checkOutput("frame_80", lastFrame, 16'h3800);
    checkOutput("frame_80_bits", lastBits, 16);
    checkOutput("frame_80_cs_low", lastLow, 128);
    waitBusyLow();
    repeat (100) @(negedge clk);
    checkOutput("settled_frames", frameCount, n2 + 2);
    checkOutput("sdi_on_falling", sdiViol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/stepper_drive_output.md
STEPPER_DRIVE_OUTPUT -- requirements
Module: stepper_drive_output

Interface
REQ-001 The block SHALL have parameter STEP_HIGH, default 4, step pulse high width in clk cycles.
REQ-002 The block SHALL have parameter SCLK_DIV, default 4, clk cycles per DAC SCLK half-period.
REQ-003 The block SHALL have parameter DAC_CMD, default 4'b0011, 4-bit DAC write-and-update command nibble.
REQ-004 Port clk, input, 1, system clock; the block SHALL use this single clock.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port enable, input, 1, run enable for step generation.
REQ-007 Port dir_in, input, 1, commanded direction.
REQ-008 Port step_period, input, 16, clk cycles per microstep pulse; 0 means stopped.
REQ-009 Port usteps, input, 2, requested microstep mode: 11=1/8, 10=1/4, 01=1/2, 00=full.
REQ-010 Port peak_current, input, 8, requested peak current DAC code.
REQ-011 Port step, output, 1, step pulse to driver.
REQ-012 Port dir, output, 1, direction to driver.
REQ-013 Port ms, output, 2, microstep mode pins to driver.
REQ-014 Port ustep_idx, output, 3, electrical position in eighths of a full step.
REQ-015 Ports dac_cs_n, dac_sclk, dac_sdi, outputs, 1 each, serial DAC interface.
REQ-016 Port dac_busy, output, 1, high while a DAC frame is in progress.

Function
REQ-017 Step generator SHALL count clk cycles 0..P-1, where P = max(step_period, 2*STEP_HIGH), and assert step for STEP_HIGH cycles starting the cycle after terminal count.
REQ-018 When enable=0 or step_period=0, the counter SHALL hold at 0 and no new pulse SHALL start; a pulse in progress SHALL complete its full STEP_HIGH width.
REQ-019 A step_period change SHALL take effect at the next terminal count or on a restart from stopped; the current interval SHALL not be truncated.
REQ-020 On each step rising edge, ustep_idx SHALL advance by 1, 2, 4 or 8 (mod 8) for ms = 11, 10, 01, 00; it SHALL decrement by the same amount when dir=0.
REQ-021 dir SHALL copy dir_in only in cycles where step=0 and the step counter is not at terminal count.
REQ-022 ms SHALL update to usteps only when ustep_idx=0 and step=0; otherwise the request SHALL remain pending and the latest usteps value SHALL be applied at the next such cycle.
REQ-023 DAC FSM states SHALL be IDLE, LOAD, SHIFT, GAP; reset state IDLE.
REQ-024 IDLE->LOAD when peak_current differs from the last written code; LOAD SHALL latch peak_current and drive dac_cs_n low.
REQ-025 SHIFT SHALL send the 16-bit frame {DAC_CMD, code, 4'b0000} MSB first; sdi changes on SCLK falling edge, and SCLK idles low with SCLK_DIV clk cycles per half-period.
REQ-026 After the 16th SCLK falling edge, dac_cs_n SHALL rise, the last written code SHALL update, and the FSM SHALL hold in GAP for 2*SCLK_DIV cycles, then return to IDLE.
REQ-027 peak_current changes during a frame SHALL not alter that frame; the new value SHALL be sent in the next frame if it still differs.
REQ-028 dac_busy SHALL be high in LOAD, SHIFT and GAP.

Reset
REQ-029 On reset: step=0, dir=0, ms=2'b11, ustep_idx=0, counter=0, dac_cs_n=1, dac_sclk=0, dac_sdi=0, dac_busy=0, last written code=8'h00, FSM=IDLE.
REQ-030 Reset mid-pulse or mid-frame SHALL abort immediately to the REQ-029 values; no partial frame SHALL complete.

Verification
REQ-031 enable=1, step_period=100, usteps=11 -> step high 4 cycles every 100 cycles; ustep_idx 0,1,...,7,0.
REQ-032 step_period=3 -> period clamped to 8 cycles (4 high, 4 low).
REQ-033 ms=11, ustep_idx=3, usteps changed to 00 -> ms stays 11 until ustep_idx wraps to 0, then becomes 00; subsequent steps leave ustep_idx=0.
REQ-034 peak_current 00->0x5A -> one frame of 16'h35A0 is sent, dac_cs_n low 16*2*SCLK_DIV cycles, dac_busy then low after the GAP cycles.
REQ-035 peak_current 0x5A->0x80 during bit 5 of a frame -> the 0x5A frame completes, then a 16'h3800 frame follows after GAP.
REQ-036 reset asserted at bit 8 of a frame and during a step pulse -> next cycle dac_cs_n=1, step=0; with peak_current still 0x5A after release, a full 16'h35A0 frame is resent.
